maxpool_2x2_stream: RTL and testbench

Downstream of the conv output stage. Consumes the 8x8 convolution output feature map as a raster stream (column index fastest, then row; same order as the output index counter: (0,0),(1,0)..(7,0),(0,1)..(7,7)). Performs 2x2 stride-2 max pooling with optional ReLU. Emits a 4x4 pooled map with its own (i,j) indices to the next layer / output buffer.

---
 rtl/maxpool_2x2_stream_if.sv | 28 ++
 rtl/maxpool_2x2_stream.sv | 116 +++++++++++
 tb/tb_maxpool_2x2_stream.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/maxpool_2x2_stream_if.sv
// Pixel stream bundle: raster conv pixels in, pooled pixels with indices out.
// Latency: n/a (wires only).
// Backpressure: none; the producer never stalls and the pooled stream is pulse-qualified.
interface maxpool_2x2_stream_if #(
    parameter int DATA_W = 16,
    parameter int CW     = 7
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     frame_start;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [CW-1:0]            out_i;
    logic [CW-1:0]            out_j;
    logic                     frame_done;

    // Producer of input pixels / consumer of pooled pixels.
    modport master (
        output in_valid, in_data, frame_start,
        input  out_valid, out_data, out_i, out_j, frame_done
    );

    // The pooling block itself.
    modport slave (
        input  in_valid, in_data, frame_start,
        output out_valid, out_data, out_i, out_j, frame_done
    );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max pooling (optional ReLU) over a raster-ordered conv feature map.
// Latency: pooled pixel registered on the edge accepting the window's bottom-right pixel.
// Backpressure: none; every in_valid cycle is consumed, outputs hold when out_valid=0.
module maxpool_2x2_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int CW     = 7,
    parameter bit RELU   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool_2x2_stream_if.slave  bus
);
    localparam int LB_N  = IMG_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef logic signed [DATA_W-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [CW-1:0] cur_col, cur_row;
    pix_t          hold_q, hold_d;
    pix_t          out_data_q, out_data_d;
    logic [CW-1:0] out_i_q, out_i_d, out_j_q, out_j_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    pix_t             in_pix, lb_rd, pair_max, win_max;
    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;

    // One half-window max per pooled column of the current row pair; never reset
    // because every entry is written on an even row before the odd row reads it.
    pix_t linebuf [LB_N];

    // Position tracking, window accumulation and pooled-output selection.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_i_d      = out_i_q;
        out_j_d      = out_j_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        in_pix  = bus.in_data;
        // frame_start forces this pixel to (0,0), dropping any partial frame.
        cur_col = bus.frame_start ? '0 : col_q;
        cur_row = bus.frame_start ? '0 : row_q;
        lb_addr = LB_AW'(cur_col >> 1);
        lb_rd   = linebuf[lb_addr];

        pair_max = (in_pix > hold_q) ? in_pix : hold_q;
        win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

        if (bus.in_valid) begin
            if (!cur_col[0]) begin
                hold_d = in_pix;
            end else if (!cur_row[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = (RELU && (win_max < 0)) ? '0 : win_max;
                out_i_d      = cur_col >> 1;
                out_j_d      = cur_row >> 1;
                frame_done_d = (cur_col == CW'(IMG_W - 1)) && (cur_row == CW'(IMG_H - 1));
            end

            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == CW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_i_q      <= '0;
            out_j_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_i_q      <= out_i_d;
            out_j_q      <= out_j_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer write; reset still blocks the write so reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst && lb_we) begin
            linebuf[lb_addr] <= pair_max;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_i      = out_i_q;
    assign bus.out_j      = out_j_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Randomized bench: two pooling instances (ReLU on/off) fed the same stream,
// checked every cycle against a frame-array reference model.
// Reports each miscompare and a final summary line.
module tb_maxpool_2x2_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;

    maxpool_2x2_stream_if #(.DATA_W(16), .CW(7)) if_a ();
    maxpool_2x2_stream_if #(.DATA_W(16), .CW(7)) if_b ();

    maxpool_2x2_stream #(.DATA_W(16), .IMG_W(8), .IMG_H(8), .CW(7), .RELU(1'b1)) u_relu (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    maxpool_2x2_stream #(.DATA_W(16), .IMG_W(8), .IMG_H(8), .CW(7), .RELU(1'b0)) u_raw (
        .clk (clk), .rst (rst), .bus (if_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic signed [15:0] img [8][8];
    int mcol = 0, mrow = 0;
    logic signed [31:0] l_relu = 0, l_raw = 0;
    int li = 0, lj = 0;
    bit ev, efd;

    logic signed [15:0] pix [64];
    logic signed [31:0] got_relu [$];
    logic signed [31:0] got_raw  [$];
    int fd_cyc [$];

    task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic signed [31:0] max2(input logic signed [31:0] a, input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic step(input bit v, input logic signed [15:0] d, input bit fs, input bit rn);
        logic signed [31:0] mx;
        if_a.in_valid = v; if_a.in_data = d; if_a.frame_start = fs;
        if_b.in_valid = v; if_b.in_data = d; if_b.frame_start = fs;
        rst = rn;
        @(posedge clk);
        cyc++;
        ev = 0; efd = 0;
        if (!rn) begin
            mcol = 0; mrow = 0; l_relu = 0; l_raw = 0; li = 0; lj = 0;
        end else if (v) begin
            if (fs) begin mcol = 0; mrow = 0; end
            img[mrow][mcol] = d;
            if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
                mx = max2(max2(img[mrow-1][mcol-1], img[mrow-1][mcol]),
                          max2(img[mrow][mcol-1],   img[mrow][mcol]));
                ev = 1;
                l_raw  = mx;
                l_relu = (mx < 0) ? 0 : mx;
                li = mcol / 2; lj = mrow / 2;
                efd = (li == 3) && (lj == 3);
            end
            mcol++;
            if (mcol == 8) begin
                mcol = 0; mrow++;
                if (mrow == 8) mrow = 0;
            end
        end
        @(negedge clk);
        check_val("relu_vld",  if_a.out_valid,  ev);
        check_val("raw_vld",   if_b.out_valid,  ev);
        check_val("relu_fd",   if_a.frame_done, efd);
        check_val("raw_fd",    if_b.frame_done, efd);
        check_val("relu_data", if_a.out_data,   l_relu);
        check_val("raw_data",  if_b.out_data,   l_raw);
        check_val("relu_i",    if_a.out_i,      li);
        check_val("relu_j",    if_a.out_j,      lj);
        check_val("raw_i",     if_b.out_i,      li);
        check_val("raw_j",     if_b.out_j,      lj);
        if (if_a.out_valid === 1'b1) got_relu.push_back(if_a.out_data);
        if (if_b.out_valid === 1'b1) got_raw.push_back(if_b.out_data);
        if (if_a.frame_done === 1'b1) fd_cyc.push_back(cyc);
    endtask

    // Feed n pixels of pix[], with idle cycles (random data/frame_start) at gap_pct.
    task automatic feed(input int n, input int gap_pct, input bit fs_first);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct)
                step(1'b0, 16'($urandom), 1'($urandom), 1'b1);
            step(1'b1, pix[k], fs_first && (k == 0), 1'b1);
        end
    endtask

    task automatic fill_ramp(input int ofs);
        for (int k = 0; k < 64; k++) pix[k] = 16'(k + ofs);
    endtask

    task automatic clear_caps();
        got_relu.delete(); got_raw.delete(); fd_cyc.delete();
    endtask

    // Compare captured ReLU outputs against the ramp pooled values plus ofs.
    task automatic check_ramp_caps(input string tag, input int first, input int ofs);
        for (int k = 0; k < 16; k++) begin
            if (first + k < got_relu.size())
                check_val(tag, got_relu[first + k], 8 * (2 * (k / 4) + 1) + 2 * (k % 4) + 1 + ofs);
            else
                check_val({tag, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        // reset state
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        check_val("rst_vld", if_a.out_valid, 0);
        check_val("rst_data", if_a.out_data, 0);

        // ramp frame, contiguous
        clear_caps();
        fill_ramp(0);
        feed(64, 0, 1'b1);
        check_val("ramp_cnt", got_relu.size(), 16);
        check_ramp_caps("ramp_val", 0, 0);
        check_val("ramp_fd_cnt", fd_cyc.size(), 1);

        // all -5: ReLU clamps to 0, raw passes -5
        clear_caps();
        for (int k = 0; k < 64; k++) pix[k] = -16'sd5;
        feed(64, 0, 1'b1);
        check_val("neg_cnt", got_raw.size(), 16);
        for (int k = 0; k < got_raw.size(); k++) begin
            check_val("neg_raw", got_raw[k], -5);
            check_val("neg_relu", got_relu[k], 0);
        end

        // window {-7,-3,-9,-100}
        clear_caps();
        for (int k = 0; k < 64; k++) pix[k] = 16'($urandom);
        pix[0] = -16'sd7; pix[1] = -16'sd3; pix[8] = -16'sd9; pix[9] = -16'sd100;
        feed(64, 0, 1'b1);
        if (got_raw.size() > 0) check_val("win_raw", got_raw[0], -3);
        else check_val("win_missing", 0, 1);

        // ramp with ~50% valid gaps
        clear_caps();
        fill_ramp(0);
        feed(64, 50, 1'b1);
        check_val("gap_cnt", got_relu.size(), 16);
        check_ramp_caps("gap_val", 0, 0);

        // reset mid-frame, then a full ramp frame without frame_start
        feed(20, 0, 1'b1);
        step(1'b1, 16'sd999, 1'b0, 1'b0);
        clear_caps();
        feed(64, 0, 1'b0);
        check_val("rstmid_cnt", got_relu.size(), 16);
        check_ramp_caps("rstmid_val", 0, 0);

        // 30 pixels of 1000 then frame_start resync
        for (int k = 0; k < 30; k++) pix[k] = 16'sd1000;
        feed(30, 0, 1'b0);
        clear_caps();
        fill_ramp(0);
        feed(64, 0, 1'b1);
        check_val("resync_cnt", got_relu.size(), 16);
        check_ramp_caps("resync_val", 0, 0);

        // back-to-back ramp frames, second offset by 100
        clear_caps();
        fill_ramp(0);
        feed(64, 0, 1'b1);
        fill_ramp(100);
        feed(64, 0, 1'b1);
        check_val("b2b_cnt", got_relu.size(), 32);
        check_ramp_caps("b2b_first", 0, 0);
        check_ramp_caps("b2b_second", 16, 100);
        check_val("b2b_fd_cnt", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2) check_val("b2b_fd_gap", fd_cyc[1] - fd_cyc[0], 64);

        // random signed frames with random gaps and occasional reset
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 64; k++) pix[k] = 16'($urandom_range(400)) - 16'sd200;
            feed(64, 30, 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) step(1'b1, 16'sd7, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
